// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing control for a 5-stage pipeline.
// Produces operand forwarding selects for E, load-use stalls and branch flushes.
// Also runs a multi-cycle mul/div FSM that holds F/D/E and bubbles E/M until the op completes.
// Optional feature: define HAZARD_PERF_EN to add the StallCnt/FlushCnt performance counters.
module hazard_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned MD_LATENCY     = 4,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      RegWriteM,
   input  logic                      RegWriteW,
   input  logic                      LoadE,
   input  logic                      PCSrcE,
   input  logic                      MdStartE,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushM,
   output logic                      MdBusy
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]      StallCnt,
   output logic [CNT_WIDTH-1:0]      FlushCnt
`endif
);

   // cnt holds the number of BUSY cycles still to run, including the current one
   localparam int unsigned CntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
   localparam logic [CntW-1:0] LoadVal = CntW'(MD_LATENCY - 2);
   localparam logic [CntW-1:0] LastVal = CntW'(1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

   md_state_e           state;
   logic [CntW-1:0]     cnt;
   logic                md_busy_q;
   logic [1:0]          fwd_a;
   logic [1:0]          fwd_b;
   logic                lw_stall;
   logic                md_hold;

   // Mul/div sequencer: the op sits in E for MD_LATENCY cycles, the last one in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         cnt       <= '0;
         md_busy_q <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (MdStartE) begin
                  if (MD_LATENCY > 2) begin
                     state     <= StBusy;
                     cnt       <= LoadVal;
                     md_busy_q <= 1'b1;
                  end else begin
                     state <= StDone;
                  end
               end
            end
            StBusy: begin
               if (cnt == LastVal) begin
                  state     <= StDone;
                  cnt       <= '0;
                  md_busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - LastVal;
               end
            end
            // MdStartE is ignored here: the op leaves E on this edge
            StDone: begin
               state     <= StIdle;
               md_busy_q <= 1'b0;
            end
            default: begin
               state     <= StIdle;
               cnt       <= '0;
               md_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Forwarding selects and hazard terms; M has priority over W, x0 is never forwarded
   always_comb begin
      fwd_a = 2'b00;
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
         fwd_a = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
         fwd_a = 2'b01;
      end
      fwd_b = 2'b00;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
         fwd_b = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
         fwd_b = 2'b01;
      end
      lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
      md_hold  = ((state == StIdle) && MdStartE) || (state == StBusy);
   end

   // Pipeline control outputs; reset forces bubbles everywhere and no stalls
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      if (!rst) begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         StallF    = lw_stall | md_hold;
         StallD    = lw_stall | md_hold;
         StallE    = md_hold;
         FlushD    = PCSrcE & ~md_hold;
         // E must keep the mul/div op, so the hold masks the load-use bubble
         FlushE    = (lw_stall | PCSrcE) & ~md_hold;
         FlushM    = md_hold;
      end
   end

   assign MdBusy = md_busy_q;

`ifdef HAZARD_PERF_EN
   // Performance counters, wrapping at 2^CNT_WIDTH
   always_ff @(posedge clk) begin
      if (rst) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (StallF) begin
            StallCnt <= StallCnt + 1'b1;
         end
         if (FlushD || FlushE) begin
            FlushCnt <= FlushCnt + 1'b1;
         end
      end
   end
`endif

endmodule
